// File: rtl/clk_sup_pkg.sv
// Shared types and defaults for the clock supervisor / glitch-free mux.
package clk_sup_pkg;

  // Source-switch handshake states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIS_OLD = 2'd1,
    EN_NEW  = 2'd2
  } sw_state_t;

  localparam int DEF_N_EXT     = 2;
  localparam int DEF_DIV_W     = 3;
  localparam int DEF_WIN_LEN   = 64;
  localparam int DEF_MIN_EDGES = 4;
  localparam int DEF_SW_TO     = 32;

  // Width of a source index: sources are 0 (ref clk) .. n_ext
  function automatic int sw_w(input int n_ext);
    return (n_ext < 1) ? 1 : $clog2(n_ext + 1);
  endfunction

endpackage

// File: rtl/clk_sup_gate.sv
// Per-source enable gate: enable captured on the source rising edge and
// applied on its falling edge so the gated clock can only change while low.
// kill force-clears a source whose clock has stopped.
module clk_sup_gate #(
  parameter logic RST_EN = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src_clk,
  input  logic en,
  input  logic kill,
  output logic gated,
  output logic ack
);

  logic en_s1, en_q, ack_s1;

  // Capture enable request in the source domain
  always_ff @(posedge src_clk or negedge rst_n or posedge kill)
    if (!rst_n)    en_s1 <= RST_EN;
    else if (kill) en_s1 <= 1'b0;
    else           en_s1 <= en;

  // Apply enable on the falling edge so the gate opens/closes while src is low
  always_ff @(negedge src_clk or negedge rst_n or posedge kill)
    if (!rst_n)    en_q <= RST_EN;
    else if (kill) en_q <= 1'b0;
    else           en_q <= en_s1;

  assign gated = src_clk & en_q;

  // Bring the applied enable back into the reference domain as acknowledge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {ack, ack_s1} <= {RST_EN, RST_EN};
    else        {ack, ack_s1} <= {ack_s1, en_q};

endmodule

// File: rtl/clk_sup_mux.sv
// Clock supervisor: per-source frequency monitor, glitch-free source mux,
// post-mux divider and output reset synchronizer.
// Optional automatic failover to the reference clock: CLK_SUP_FAILOVER_EN.
module clk_sup_mux import clk_sup_pkg::*; #(
  parameter int N_EXT     = DEF_N_EXT,
  parameter int DIV_W     = DEF_DIV_W,
  parameter int WIN_LEN   = DEF_WIN_LEN,
  parameter int MIN_EDGES = DEF_MIN_EDGES,
  parameter int SW_TO     = DEF_SW_TO
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_EXT-1:0]         xclk,
  input  logic [sw_w(N_EXT)-1:0]   req_sel,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [DIV_W-1:0]         div_sel,
  output logic                     clk_out,
  output logic                     rst_out_n,
  output logic [sw_w(N_EXT)-1:0]   cur_sel,
  output logic [N_EXT:0]           clk_ok,
  output logic                     req_err,
  output logic                     fail_irq
);

  localparam int SW = sw_w(N_EXT);
  localparam int NS = N_EXT + 1;
  localparam int EW = $clog2(MIN_EDGES + 1);
  localparam int WW = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
  localparam int TW = $clog2(SW_TO + 1);

  // ---------------- frequency monitor ----------------
  logic [WW-1:0] win;
  logic          win_wrap;

  assign win_wrap = (win == WW'(WIN_LEN - 1));

  // Shared window counter; all health bits update on its wrap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) win <= '0;
    else        win <= win_wrap ? '0 : win + WW'(1);

  assign clk_ok[0] = 1'b1;

  for (genvar i = 0; i < N_EXT; i++) begin : g_mon
    logic          tgl, ok, edge_seen;
    logic [2:0]    sy;
    logic [EW-1:0] cnt;

    // Toggle once per source rising edge, in the source's own domain
    always_ff @(posedge xclk[i] or negedge rst_n)
      if (!rst_n) tgl <= 1'b0;
      else        tgl <= ~tgl;

    assign edge_seen = sy[2] ^ sy[1];

    // Synchronize toggle, count changes (saturating), judge at window wrap
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        sy  <= '0;
        cnt <= '0;
        ok  <= 1'b1;
      end else begin
        sy <= {sy[1:0], tgl};
        if (win_wrap) begin
          ok  <= (cnt >= EW'(MIN_EDGES));
          cnt <= '0;
        end else if (edge_seen && (cnt != EW'(MIN_EDGES))) begin
          cnt <= cnt + EW'(1);
        end
      end

    assign clk_ok[i+1] = ok;
  end

  // ---------------- per-source gates ----------------
  logic [NS-1:0] src, gated, ack, en, kill;
  logic          mclk;

  assign src = {xclk, clk};

  for (genvar s = 0; s < NS; s++) begin : g_gate
    clk_sup_gate #(.RST_EN((s == 0) ? 1'b1 : 1'b0)) u_gate (
      .clk     (clk),
      .rst_n   (rst_n),
      .src_clk (src[s]),
      .en      (en[s]),
      .kill    (kill[s]),
      .gated   (gated[s]),
      .ack     (ack[s])
    );
  end

  // Break-before-make guarantees at most one gate open at a time
  assign mclk = |gated;

  // ---------------- switch FSM ----------------
  sw_state_t     state, state_nx;
  logic [SW-1:0] cur_nx, tgt, tgt_nx;
  logic [NS-1:0] en_nx, kill_nx;
  logic [TW-1:0] tmo, tmo_nx;
  logic          fo_hold, fo_nx, err_nx, irq_nx, fo_trig, bad_req;

`ifdef CLK_SUP_FAILOVER_EN
  assign fo_trig = (state == IDLE) && !clk_ok[cur_sel];
`else
  assign fo_trig = 1'b0;
`endif

  assign bad_req = (req_sel > SW'(N_EXT)) || (req_sel == cur_sel) || !clk_ok[req_sel];

  // FSM and handshake registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      cur_sel  <= '0;
      tgt      <= '0;
      en       <= {{N_EXT{1'b0}}, 1'b1};
      kill     <= '0;
      tmo      <= '0;
      fo_hold  <= 1'b0;
      req_err  <= 1'b0;
      fail_irq <= 1'b0;
    end else begin
      state    <= state_nx;
      cur_sel  <= cur_nx;
      tgt      <= tgt_nx;
      en       <= en_nx;
      kill     <= kill_nx;
      tmo      <= tmo_nx;
      fo_hold  <= fo_nx;
      req_err  <= err_nx;
      fail_irq <= irq_nx;
    end

  // Next-state: failover wins over a same-cycle request (ready held low then)
  always_comb begin
    state_nx  = state;
    cur_nx    = cur_sel;
    tgt_nx    = tgt;
    en_nx     = en;
    kill_nx   = kill;
    tmo_nx    = tmo;
    fo_nx     = fo_hold;
    err_nx    = 1'b0;
    irq_nx    = 1'b0;
    req_ready = (state == IDLE) && !fo_trig;
    case (state)
      IDLE: begin
        if (fo_trig) begin
          irq_nx         = 1'b1;
          fo_nx          = 1'b1;
          tgt_nx         = '0;
          en_nx[cur_sel] = 1'b0;
          tmo_nx         = '0;
          state_nx       = DIS_OLD;
        end else if (req_valid) begin
          if (bad_req) begin
            err_nx = 1'b1;
          end else begin
            tgt_nx         = req_sel;
            en_nx[cur_sel] = 1'b0;
            tmo_nx         = '0;
            state_nx       = DIS_OLD;
          end
        end
      end
      DIS_OLD: begin
        if (!ack[cur_sel]) begin
          en_nx[tgt]   = 1'b1;
          kill_nx[tgt] = 1'b0;
          state_nx     = EN_NEW;
        end else if (tmo == TW'(SW_TO - 1)) begin
          // Old clock never acknowledged (likely stopped): clear it by force
          kill_nx[cur_sel] = 1'b1;
          en_nx[tgt]       = 1'b1;
          kill_nx[tgt]     = 1'b0;
          state_nx         = EN_NEW;
        end else begin
          tmo_nx = tmo + TW'(1);
        end
      end
      EN_NEW: begin
        if (ack[tgt]) begin
          cur_nx   = tgt;
          fo_nx    = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- post-mux divider ----------------
  logic [DIV_W-1:0] dcnt, dv;
  logic [DIV_W:0]   cnt_nx, lowlen;
  logic             dq, byp, tc;

  assign tc     = (dcnt == dv);
  assign cnt_nx = {1'b0, dcnt} + (DIV_W+1)'(1);
  assign lowlen = ({1'b0, dv} + (DIV_W+1)'(1)) >> 1;

  // Counter; new divide value taken only at terminal count. Output is low
  // in the first half of a period so mode changes happen while it is low.
  always_ff @(posedge mclk or negedge rst_n)
    if (!rst_n) begin
      dcnt <= '0;
      dv   <= '0;
      dq   <= 1'b1;
    end else if (tc) begin
      dcnt <= '0;
      dv   <= div_sel;
      dq   <= (div_sel == '0);
    end else begin
      dcnt <= dcnt + DIV_W'(1);
      dq   <= (cnt_nx >= lowlen);
    end

  // Bypass select moves on the falling edge, when mclk and dq are both low
  // or the change is monotonic
  always_ff @(negedge mclk or negedge rst_n)
    if (!rst_n) byp <= 1'b1;
    else        byp <= (dv == '0);

  assign clk_out = byp ? mclk : dq;

  // ---------------- output reset ----------------
  logic [3:0] rsr;
  logic       rst_src_n;

  assign rst_src_n = rst_n & ~fo_hold;

  // Assert asynchronously, release after four clk_out rising edges
  always_ff @(posedge clk_out or negedge rst_src_n)
    if (!rst_src_n) rsr <= '0;
    else            rsr <= {rsr[2:0], 1'b1};

  assign rst_out_n = rsr[3];

endmodule

// File: tb/tb_clk_sup_mux.sv
// Directed bench for clk_sup_mux: reset, switching, request errors, divider,
// loss-of-clock behaviour (with or without CLK_SUP_FAILOVER_EN), reset abort.
`timescale 1ns/1ps
module tb_clk_sup_mux;

  logic       clk, rst_n, xc0, x0_run;
  logic [1:0] xclk, req_sel, cur_sel;
  logic       req_valid, req_ready, clk_out, rst_out_n, req_err, fail_irq;
  logic [2:0] div_sel, clk_ok;

  int  checks = 0, failures = 0;
  int  irqs = 0, rfall = 0, irq0, rf0;
  real t_edge = 0.0, t_rise = 0.0, per = 0.0, min_hi = 1.0e9, min_lo = 1.0e9;

  assign xclk = {1'b0, xc0};

  clk_sup_mux dut (
    .clk(clk), .rst_n(rst_n), .xclk(xclk), .req_sel(req_sel),
    .req_valid(req_valid), .req_ready(req_ready), .div_sel(div_sel),
    .clk_out(clk_out), .rst_out_n(rst_out_n), .cur_sel(cur_sel),
    .clk_ok(clk_ok), .req_err(req_err), .fail_irq(fail_irq)
  );

  initial begin clk = 0; forever #62.5 clk = ~clk; end

  // 25 MHz external clock; when stopped it always parks low
  initial begin
    xc0 = 0;
    #7;
    forever begin #20; if (x0_run || xc0) xc0 = ~xc0; end
  end

  always @(clk_out) begin
    if (clk_out === 1'b0 && ($realtime - t_edge) < min_hi) min_hi = $realtime - t_edge;
    if (clk_out === 1'b1 && ($realtime - t_edge) < min_lo) min_lo = $realtime - t_edge;
    t_edge = $realtime;
  end

  always @(posedge clk_out) begin per = $realtime - t_rise; t_rise = $realtime; end
  always @(negedge rst_out_n) rfall++;
  always @(negedge clk) if (fail_irq === 1'b1) irqs++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] per_ns();
    return 32'($rtoi(per + 0.5));
  endfunction

  function automatic logic [31:0] alive();
    return 32'(($realtime - t_rise) < 400.0);
  endfunction

  task automatic clr_min();
    min_hi = 1.0e9;
    min_lo = 1.0e9;
  endtask

  initial begin
    rst_n = 0; x0_run = 1; req_valid = 0; req_sel = 0; div_sel = 0;

    // reset state
    #300; @(negedge clk);
    chk("rst_cur_sel", 32'(cur_sel), 0);
    chk("rst_rst_out_n", 32'(rst_out_n), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_clk_ok", 32'(clk_ok), 32'h7);
    chk("rst_req_err", 32'(req_err), 0);
    chk("rst_fail_irq", 32'(fail_irq), 0);

    // release: rst_out_n after exactly 4 clk_out edges, clk_out = 8 MHz
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1 chk("rel_after3", 32'(rst_out_n), 0);
    @(posedge clk);
    #1 chk("rel_after4", 32'(rst_out_n), 1);
    #1250;
    chk("per_8mhz", per_ns(), 125);
    chk("alive_8mhz", alive(), 1);

    // first window done: xclk[0] healthy, stopped xclk[1] unhealthy
    repeat (80) @(negedge clk);
    chk("ok_window1", 32'(clk_ok), 32'h3);

    // switch to source 1
    clr_min();
    req_sel = 1; req_valid = 1;
    @(posedge clk);
    #1 chk("sw1_ready_low", 32'(req_ready), 0);
    req_valid = 0;
    for (int i = 0; i < 10 && cur_sel !== 2'd1; i++) @(negedge clk);
    chk("sw1_cur_sel", 32'(cur_sel), 1);
    #400;
    chk("per_25mhz", per_ns(), 40);
    chk("sw1_min_hi", 32'(min_hi >= 19.9), 1);
    chk("sw1_min_lo", 32'(min_lo >= 19.9), 1);

    // rejected requests: stopped source, out of range, already active
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_sel = (k == 0) ? 2'd2 : (k == 1) ? 2'd3 : 2'd1;
      req_valid = 1;
      @(posedge clk);
      #1 chk("err_pulse", 32'(req_err), 1);
      chk("err_cur_sel", 32'(cur_sel), 1);
      req_valid = 0;
      @(posedge clk);
      #1 chk("err_clear", 32'(req_err), 0);
    end

    // divider 0 -> 3 -> 0 on 25 MHz
    @(negedge clk);
    clr_min();
    div_sel = 3;
    #800;
    chk("per_div4", per_ns(), 160);
    chk("div_min_hi", 32'(min_hi >= 19.9), 1);
    chk("div_min_lo", 32'(min_lo >= 19.9), 1);
    div_sel = 0;
    #800;
    chk("per_div1", per_ns(), 40);
    chk("div_back_min", 32'(min_hi >= 19.9 && min_lo >= 19.9), 1);

    // loss of the active external clock
    irq0 = irqs; rf0 = rfall;
    clr_min();
    x0_run = 0;
    for (int i = 0; i < 140 && clk_ok[1] !== 1'b0; i++) @(negedge clk);
    chk("lost_ok", 32'(clk_ok), 32'h1);
`ifdef CLK_SUP_FAILOVER_EN
    for (int i = 0; i < 60 && cur_sel !== 2'd0; i++) @(negedge clk);
    chk("fo_cur_sel", 32'(cur_sel), 0);
    chk("fo_irq_count", 32'(irqs - irq0), 1);
    chk("fo_rst_pulse", 32'(rfall - rf0), 1);
    for (int i = 0; i < 12 && rst_out_n !== 1'b1; i++) @(negedge clk);
    chk("fo_rst_release", 32'(rst_out_n), 1);
    #1000;
    chk("fo_per_8mhz", per_ns(), 125);
    chk("fo_min_hi", 32'(min_hi >= 19.9), 1);
`else
    repeat (60) @(negedge clk);
    chk("nofo_cur_sel", 32'(cur_sel), 1);
    chk("nofo_irq_count", 32'(irqs - irq0), 0);
    chk("nofo_rst_out_n", 32'(rst_out_n), 1);
`endif

    // reset asserted in DIS_OLD aborts straight to source 0
    x0_run = 1;
    repeat (140) @(negedge clk);
    chk("ok_restored", 32'(clk_ok), 32'h3);
`ifdef CLK_SUP_FAILOVER_EN
    req_sel = 1;
`else
    req_sel = 0;
`endif
    req_valid = 1;
    @(posedge clk);
    #1 chk("abort_busy", 32'(req_ready), 0);
    req_valid = 0;
    #5 rst_n = 0;
    #1;
    chk("abort_cur_sel", 32'(cur_sel), 0);
    chk("abort_idle", 32'(req_ready), 1);
    chk("abort_rst_out_n", 32'(rst_out_n), 0);
    #1000;
    chk("abort_per_8mhz", per_ns(), 125);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8 && rst_out_n !== 1'b1; i++) @(negedge clk);
    chk("abort_release", 32'(rst_out_n), 1);
    chk("abort_final_sel", 32'(cur_sel), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_sup_mux.md
CLK_SUP_MUX -- requirements
Module: clk_sup_mux

Interface
REQ-001 SHALL have parameter N_EXT, default 2, giving the number of external clock inputs (1..7).
REQ-002 SHALL have parameter DIV_W, default 3, giving the post-mux divider select width.
REQ-003 SHALL have parameter WIN_LEN, default 64, giving the monitor window length in clk cycles.
REQ-004 SHALL have parameter MIN_EDGES, default 4, giving the minimum source rising edges per window for a source to be healthy.
REQ-005 SHALL have parameter SW_TO, default 32, giving the switch-handshake timeout in clk cycles.
REQ-006 SHALL have the port clk, input, 1 bit: always-running reference clock, also selectable source 0.
REQ-007 SHALL have the port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have the port xclk, input, N_EXT bits: external clocks, selectable as sources 1..N_EXT.
REQ-009 SHALL have the port req_sel, input, SW bits (SW = clog2(N_EXT+1)): requested source index.
REQ-010 SHALL have the port req_valid / req_ready, input / output, 1 bit each: switch request handshake.
REQ-011 SHALL have the port div_sel, input, DIV_W bits: clk_out = muxed clock / (div_sel+1).
REQ-012 SHALL have the port clk_out, output, 1 bit: glitch-free divided clock.
REQ-013 SHALL have the port rst_out_n, output, 1 bit: reset, asserted asynchronously and released synchronously to clk_out.
REQ-014 SHALL have the port cur_sel, output, SW bits: currently active source.
REQ-015 SHALL have the port clk_ok, output, N_EXT+1 bits: per-source health (bit 0 is constant 1).
REQ-016 SHALL have the port req_err / fail_irq, output, 1 bit each: one-cycle clk-domain pulses.

Function
REQ-017 SHALL monitor each xclk with a toggle flop in its own domain plus a 2-flop synchronizer into clk, counting synchronized edges per window; clk_ok[i] SHALL update once per window, at the window wrap (WIN_LEN-1 -> 0).
REQ-018 SHALL use a saturating edge counter, so an over-frequency source does not wrap to unhealthy.
REQ-019 SHALL implement switch FSM states IDLE, DIS_OLD, EN_NEW; req_ready=1 only in IDLE.
REQ-020 IDLE SHALL on req_valid&req_ready: if req_sel>N_EXT, req_sel==cur_sel, or clk_ok[req_sel]=0, pulse req_err and stay IDLE; otherwise go to DIS_OLD.
REQ-021 DIS_OLD SHALL clear the old source enable (taking effect on the old clock's falling edge) and wait for its synchronized acknowledge; after SW_TO cycles without acknowledge it SHALL force-clear and proceed to EN_NEW.
REQ-022 EN_NEW SHALL set the new enable (on the new clock's falling edge), wait for its acknowledge, then update cur_sel and return to IDLE.
REQ-023 SHALL allow no clk_out pulse shorter than the narrower source half-period.
REQ-024 SHALL load div_sel into the divider only at divider terminal count; div_sel=0 SHALL pass the muxed clock through.
REQ-025 SHALL give failover priority over a request arriving in the same cycle.

Reset
REQ-026 SHALL, on rst_n low, reset to: cur_sel=0, FSM IDLE, enable of source 0 only, clk_ok all 1, divider count 0 with divide value 1, req_err=0, fail_irq=0, rst_out_n=0.
REQ-027 SHALL release rst_out_n after 4 clk_out rising edges following rst_n deassertion.
REQ-028 SHALL, on rst_n asserted mid-switch, abort to source 0 immediately, with no handshake.

Configuration
REQ-029 SHALL, with CLK_SUP_FAILOVER_EN defined and clk_ok[cur_sel] falling in IDLE, pulse fail_irq, assert rst_out_n, perform DIS_OLD (timeout path) then EN_NEW to source 0, and re-release rst_out_n as in REQ-027.
REQ-030 SHALL, without CLK_SUP_FAILOVER_EN, only report clk_ok, tie fail_irq to 0 and perform no automatic switching.

Structure
REQ-031 SHALL place the FSM state enum, the SW width function and the default parameter constants in package clk_sup_pkg.
REQ-032 SHALL implement the per-source enable flop pair, falling-edge enable and acknowledge synchronizer as sub-module clk_sup_gate, instantiated N_EXT+1 times.

Verification
REQ-033 Bench SHALL cover: reset release with clk=8 MHz -> cur_sel=0, rst_out_n high after 4 clk_out edges, clk_out=8 MHz.
REQ-034 Bench SHALL cover: xclk[0]=25 MHz, request sel 1 -> req_ready low, cur_sel=1 within 10 clk cycles, no glitch.
REQ-035 Bench SHALL cover: request sel 2 with xclk[1] stopped -> req_err pulse, cur_sel unchanged.
REQ-036 Bench SHALL cover: div_sel 0->3 on 25 MHz -> clk_out 6.25 MHz from the next terminal count, no runt pulse.
REQ-037 Bench SHALL cover: stop active xclk[0] with failover on -> clk_ok[1]=0 within 2 windows, fail_irq, switch to 0 via timeout, rst_out_n pulse.
REQ-038 Bench SHALL cover: rst_n low during DIS_OLD -> immediate source 0, FSM IDLE, rst_out_n=0.
